// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared constants and types for the serial-bus slave endpoint.
//   ADDR_W / DATA_W   : serial address and data frame widths
//   ID_HI / ID_LO     : slave-ID field position inside the address
//   DATA_START_IDX    : first bit index (count from 0) that also carries data
//   slave_state_e     : slave FSM state encoding
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int ADDR_W         = 14;
  localparam int DATA_W         = 8;
  localparam int ID_HI          = 13;
  localparam int ID_LO          = 12;
  localparam int DATA_START_IDX = 6;
  localparam int LAST_ADDR_IDX  = ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    DECODE   = 3'd2,
    WRITE    = 3'd3,
    RD_MEM   = 3'd4,
    RD_VALID = 3'd5,
    SEND     = 3'd6
  } slave_state_e;

  // True when the address bit with this count index also carries a data bit.
  function automatic logic is_data_idx(input logic [3:0] idx);
    return idx >= 4'(DATA_START_IDX);
  endfunction

endpackage

// File: rtl/slave_bram.sv
// ---------------------------------------------------------------------------
// slave_bram
// Single-port synchronous byte RAM, 2**ADDR_W deep, read latency 1.
// Contents are not reset.
//   i_clk    : clock, all logic on posedge
//   i_we     : write enable
//   i_re     : read enable; o_rdata updates on the following edge
//   i_addr   : byte address
//   i_wdata  : write data
//   o_rdata  : registered read data
// ---------------------------------------------------------------------------
module slave_bram #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [0:(1<<ADDR_W)-1];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_slave_port.sv
// ---------------------------------------------------------------------------
// bus_slave_port
// Slave endpoint of the serial bus. Deserialises a 14-bit address (MSB first)
// and an 8-bit write byte that rides alongside address bits 7..0, checks the
// slave ID in address bits [13:12], then writes or reads a local byte memory.
// Reads answer with a one-cycle slave_valid pulse followed by 8 serial bits.
//   clock       : system clock
//   reset       : synchronous active-high reset
//   addr_rx     : serial address bit, MSB first
//   data_rx     : serial write-data bit, MSB first
//   valid_s     : frame valid, high for the whole address/data phase
//   write_en    : 1 = write, 0 = read; sampled with address bit 13
//   slave_ready : high while a new frame can be accepted (IDLE)
//   slave_valid : one-cycle pulse, read data starts next cycle
//   data_tx     : serial read data, MSB first
//   busy_o      : high in any state other than IDLE
// ---------------------------------------------------------------------------
module bus_slave_port
  import bus_pkg::*;
#(
  parameter logic [1:0] SLAVE_ID      = 2'd0,
  parameter int         MEM_ADDR_W    = 12,
  parameter string      MEM_INIT_FILE = ""
) (
  input  logic clock,
  input  logic reset,
  input  logic addr_rx,
  input  logic data_rx,
  input  logic valid_s,
  input  logic write_en,
  output logic slave_ready,
  output logic slave_valid,
  output logic data_tx,
  output logic busy_o
);

  slave_state_e          r_state;
  slave_state_e          w_state_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_we;
  logic [3:0]            r_bit_cnt;
  logic [DATA_W-1:0]     r_tx_shift;
  logic [2:0]            r_tx_cnt;

  logic                  w_mem_we;
  logic                  w_mem_re;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  w_id_match;

  assign w_id_match = (r_addr[ID_HI:ID_LO] == SLAVE_ID);

  // -------------------------------------------------------------------------
  // Next-state and memory strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_re     = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_s) w_state_next = ADDR;
      end
      ADDR: begin
        // Dropping valid_s mid-address aborts; nothing touches memory.
        if (!valid_s) begin
          w_state_next = IDLE;
        end else if (r_bit_cnt == 4'(LAST_ADDR_IDX)) begin
          w_state_next = DECODE;
        end
      end
      DECODE: begin
        if (!w_id_match) begin
          w_state_next = IDLE;
        end else if (r_we) begin
          w_state_next = WRITE;
        end else begin
          w_state_next = RD_MEM;
        end
      end
      WRITE: begin
        w_mem_we     = 1'b1;
        w_state_next = IDLE;
      end
      RD_MEM: begin
        w_mem_re     = 1'b1;
        w_state_next = RD_VALID;
      end
      RD_VALID: begin
        w_state_next = SEND;
      end
      SEND: begin
        if (r_tx_cnt == 3'd7) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
      r_bit_cnt  <= '0;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (valid_s) begin
            // First bit is address bit 13; the shift register fills upward.
            r_addr    <= {{(ADDR_W-1){1'b0}}, addr_rx};
            r_we      <= write_en;
            r_data    <= '0;
            r_bit_cnt <= 4'd1;
          end
        end
        ADDR: begin
          if (valid_s) begin
            r_addr    <= {r_addr[ADDR_W-2:0], addr_rx};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (is_data_idx(r_bit_cnt)) begin
              r_data <= {r_data[DATA_W-2:0], data_rx};
            end
          end else begin
            r_bit_cnt <= '0;
          end
        end
        DECODE: begin
          r_bit_cnt <= '0;
        end
        RD_VALID: begin
          // RAM output registered during RD_MEM is valid now.
          r_tx_shift <= w_rd_data;
          r_tx_cnt   <= '0;
        end
        SEND: begin
          r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          r_tx_cnt   <= r_tx_cnt + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Local memory
  // -------------------------------------------------------------------------
  slave_bram #(
    .ADDR_W (MEM_ADDR_W)
  ) u_bram (
    .i_clk   (clock),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (r_addr[MEM_ADDR_W-1:0]),
    .i_wdata (r_data),
    .o_rdata (w_rd_data)
  );

  // -------------------------------------------------------------------------
  // Outputs: decoded from state and forced low while reset is asserted so
  // they read as idle/quiet in the reset cycle itself.
  // -------------------------------------------------------------------------
  assign slave_ready = !reset && (r_state == IDLE);
  assign slave_valid = !reset && (r_state == RD_VALID);
  assign data_tx     = !reset && (r_state == SEND) && r_tx_shift[DATA_W-1];
  assign busy_o      = !reset && (r_state != IDLE);

endmodule

// File: tb/tb_bus_slave_port.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_port
// Directed bench for bus_slave_port. Inputs change on the falling edge, and
// outputs are sampled on the falling edge (1 time unit after the drive).
// ---------------------------------------------------------------------------
module tb_bus_slave_port;

  logic clk;
  logic reset;
  logic addr_rx;
  logic data_rx;
  logic valid_s;
  logic write_en;
  logic slave_ready;
  logic slave_valid;
  logic data_tx;
  logic busy_o;

  int nvec;
  int nfail;

  bus_slave_port #(
    .SLAVE_ID      (2'd0),
    .MEM_ADDR_W    (12),
    .MEM_INIT_FILE ("")
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .addr_rx     (addr_rx),
    .data_rx     (data_rx),
    .valid_s     (valid_s),
    .write_en    (write_en),
    .slave_ready (slave_ready),
    .slave_valid (slave_valid),
    .data_tx     (data_tx),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serialise nbits of a frame; bit i carries addr[13-i], and from bit 6 on
  // data[13-i]. Leaves valid_s low on the falling edge after the last bit.
  task automatic send_frame(input logic [13:0] addr, input logic [7:0] data,
                            input logic we, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) begin
        chk("ready_idle", {7'b0, slave_ready}, 8'd1);
        chk("tx_idle", {7'b0, data_tx}, 8'd0);
      end
      if (i == 1) begin
        chk("ready_busy", {7'b0, slave_ready}, 8'd0);
        chk("busy_addr", {7'b0, busy_o}, 8'd1);
      end
      valid_s  = 1'b1;
      write_en = we;
      addr_rx  = addr[13-i];
      data_rx  = (i >= 6) ? data[13-i] : 1'b0;
    end
    @(negedge clk);
    valid_s  = 1'b0;
    addr_rx  = 1'b0;
    data_rx  = 1'b0;
    write_en = 1'b0;
  endtask

  // After a full write frame: memory holds the byte two edges after the last
  // address bit, and the port is ready again.
  task automatic write_tail(input logic [11:0] a, input logic [7:0] exp);
    #1;
    chk("valid_dec_w", {7'b0, slave_valid}, 8'd0);
    @(negedge clk);
    #1;
    chk("ready_wr", {7'b0, slave_ready}, 8'd0);
    @(negedge clk);
    #1;
    chk("mem_wr", dut.u_bram.r_mem[a], exp);
    chk("ready_after_wr", {7'b0, slave_ready}, 8'd1);
  endtask

  // After a full read frame: slave_valid on the third falling edge, then 8
  // data bits MSB first. reset_at (1..8) asserts reset during that bit.
  task automatic read_tail(input logic [7:0] exp, input int reset_at, input logic end_check);
    #1;
    chk("valid_dec", {7'b0, slave_valid}, 8'd0);
    @(negedge clk);
    #1;
    chk("valid_rdmem", {7'b0, slave_valid}, 8'd0);
    @(negedge clk);
    #1;
    chk("valid_pulse", {7'b0, slave_valid}, 8'd1);
    chk("tx_rdvalid", {7'b0, data_tx}, 8'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("rd_bit", {7'b0, data_tx}, {7'b0, exp[7-k]});
      chk("valid_send", {7'b0, slave_valid}, 8'd0);
      if (reset_at == k + 1) begin
        reset = 1'b1;
        #1;
        chk("rst_tx", {7'b0, data_tx}, 8'd0);
        chk("rst_valid", {7'b0, slave_valid}, 8'd0);
        chk("rst_ready", {7'b0, slave_ready}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_post_rst", {7'b0, slave_ready}, 8'd1);
        chk("busy_post_rst", {7'b0, busy_o}, 8'd0);
        return;
      end
    end
    if (end_check) begin
      @(negedge clk);
      #1;
      chk("tx_after", {7'b0, data_tx}, 8'd0);
      chk("ready_after_rd", {7'b0, slave_ready}, 8'd1);
    end
  endtask

  initial begin
    nvec     = 0;
    nfail    = 0;
    reset    = 1'b1;
    addr_rx  = 1'b0;
    data_rx  = 1'b0;
    valid_s  = 1'b0;
    write_en = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready0", {7'b0, slave_ready}, 8'd0);
    chk("rst_valid0", {7'b0, slave_valid}, 8'd0);
    chk("rst_tx0", {7'b0, data_tx}, 8'd0);
    chk("rst_busy0", {7'b0, busy_o}, 8'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_first", {7'b0, slave_ready}, 8'd1);

    // Write A5 to 0x123
    send_frame(14'h0123, 8'hA5, 1'b1, 14);
    write_tail(12'h123, 8'hA5);

    // Read 0x123 -> 1,0,1,0,0,1,0,1; leave the port in its last SEND bit
    send_frame(14'h0123, 8'h00, 1'b0, 14);
    read_tail(8'hA5, 0, 1'b0);

    // Back-to-back: next frame starts on the IDLE re-entry cycle
    send_frame(14'h0124, 8'h3C, 1'b1, 14);
    write_tail(12'h124, 8'h3C);
    send_frame(14'h0124, 8'h00, 1'b0, 14);
    read_tail(8'h3C, 0, 1'b1);

    // ID mismatch: 0x1123 carries ID 1
    send_frame(14'h1123, 8'hFF, 1'b1, 14);
    #1;
    chk("mis_busy_dec", {7'b0, busy_o}, 8'd1);
    chk("mis_valid_dec", {7'b0, slave_valid}, 8'd0);
    @(negedge clk);
    #1;
    chk("mis_ready", {7'b0, slave_ready}, 8'd1);
    chk("mis_valid", {7'b0, slave_valid}, 8'd0);
    @(negedge clk);
    #1;
    chk("mis_mem", dut.u_bram.r_mem[12'h123], 8'hA5);

    // Abort: preload 0x040, then drop valid_s after 9 bits of a write
    send_frame(14'h0040, 8'h5A, 1'b1, 14);
    write_tail(12'h040, 8'h5A);
    send_frame(14'h0040, 8'hC3, 1'b1, 9);
    #1;
    chk("abort_busy", {7'b0, busy_o}, 8'd1);
    @(negedge clk);
    #1;
    chk("abort_ready", {7'b0, slave_ready}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort_mem", dut.u_bram.r_mem[12'h040], 8'h5A);
    chk("abort_valid", {7'b0, slave_valid}, 8'd0);

    // Reset during the 4th SEND bit, then a clean read
    send_frame(14'h0123, 8'h00, 1'b0, 14);
    read_tail(8'hA5, 4, 1'b0);
    send_frame(14'h0123, 8'h00, 1'b0, 14);
    read_tail(8'hA5, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/bus_slave_port.md
Name: bus_slave_port

Overview:
- Slave-side endpoint of the serial bus. Sits directly downstream of the bus master.
- Deserialises the 14-bit address and the 8-bit write data arriving on single wires, then decodes a slave ID.
- Writes to or reads from a local byte memory.
- For reads, returns the byte serially after a one-cycle slave_valid pulse.

Parameters:
- SLAVE_ID, 2'd0, value matched against address bits [13:12]; mismatched transfers are consumed and ignored.
- MEM_ADDR_W, 12, local memory index width; address bits [MEM_ADDR_W-1:0] select the byte (max 12).
- MEM_INIT_FILE, "", optional hex init file for the local memory.

Ports:
- clock  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- addr_rx  input  1  serial address bit from master, MSB first
- data_rx  input  1  serial write-data bit from master, MSB first
- valid_s  input  1  master frame-valid; high for the whole address/data phase
- write_en  input  1  1 = write, 0 = read; sampled with address bit 13
- slave_ready  output  1  high when the port can accept a new frame
- slave_valid  output  1  one-cycle pulse: read data follows next cycle
- data_tx  output  1  serial read data to master, MSB first
- busy_o  output  1  high in any state other than IDLE (debug/LED)

Behaviour:
- Reset values: slave_ready=0 during reset and 1 on the first cycle after it; slave_valid=0, data_tx=0, busy_o=0; state=IDLE; counters=0.
- Reset does not clear memory contents. Reset mid-frame aborts the frame with no memory write.
- IDLE:
  - slave_ready=1.
  - On an edge with valid_s=1: capture addr_rx as address bit 13 and latch write_en, set bit_cnt=1, go to ADDR.
- ADDR:
  - slave_ready=0.
  - Each edge with valid_s=1 shifts addr_rx into the address shift register and increments bit_cnt.
  - Bits with count index 6..13 (address bits 7..0) also shift data_rx into the data register, so data arrives MSB first alongside those bits.
  - The edge that captures index 13 moves to DECODE.
  - If valid_s=0 before index 13, the frame is aborted and the state returns to IDLE; no memory access occurs.
- DECODE (1 cycle):
  - If addr[13:12] != SLAVE_ID, go to IDLE.
  - Otherwise go to WRITE when the latched write_en=1, or to RD_MEM when it is 0.
- WRITE (1 cycle): mem[addr[MEM_ADDR_W-1:0]] <= data register; then go to IDLE.
- RD_MEM (1 cycle): synchronous memory read is issued; the result is loaded into the tx shift register on the next edge.
- RD_VALID (1 cycle): slave_valid=1, data_tx=0; then go to SEND with tx_cnt=0.
- SEND (8 cycles):
  - data_tx = tx_shift[7], shifting left each edge, so bit 7 appears in the first SEND cycle and bit 0 in the eighth.
  - After tx_cnt reaches 7, go to IDLE with data_tx=0.
- Latencies:
  - Write: the memory is updated 2 edges after the last address bit.
  - Read: slave_valid is high 3 cycles after the last address bit; the data byte completes 8 cycles later.
  - slave_ready stays low from the first captured bit until the return to IDLE.
- valid_s is ignored in DECODE, WRITE, RD_MEM, RD_VALID and SEND. A new frame is accepted only from IDLE.
- Back-to-back frames: valid_s may rise on the same cycle the state returns to IDLE.
- Address/ID bits beyond MEM_ADDR_W below bit 12 are don't-care. Addressing is direct, with no wrap logic.

Decomposition:
- Shared package (bus_pkg):
  - ADDR_W=14, DATA_W=8, ID_HI=13, ID_LO=12.
  - DATA_START_IDX=6.
  - slave state encoding: IDLE, ADDR, DECODE, WRITE, RD_MEM, RD_VALID, SEND.
- One sub-module: slave_bram, a single-port synchronous RAM with 8-bit data, 2**MEM_ADDR_W depth, and read latency 1.

Test Plan:
- Write: SLAVE_ID=0, serialise addr 14'h0123 with data 8'hA5 on indices 6..13 and write_en=1 -> mem[12'h123]==8'hA5 two edges after the last bit; slave_ready low from the first bit and high again after WRITE.
- Read: same address with write_en=0 after the write above -> slave_valid pulses exactly once, 3 cycles after the last bit; data_tx then carries 1,0,1,0,0,1,0,1 over 8 cycles, then 0.
- ID mismatch: addr 14'h1123 (ID=1) write of 8'hFF -> no memory change; slave_valid never asserts; back to IDLE after DECODE.
- Abort: drop valid_s after 9 bits of a write to 14'h0040 -> return to IDLE, mem[12'h040] unchanged, slave_ready=1 the next cycle.
- Reset mid-SEND: assert reset during the 4th SEND bit -> data_tx=0, slave_valid=0, slave_ready=0 in the reset cycle; a subsequent read of 14'h0123 still returns 8'hA5.
- Back-to-back: start a second write frame to 14'h0124 with 8'h3C on the cycle IDLE is re-entered after a read -> accepted and written correctly.
